// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, redirect tracking and IF/ID pipeline register.
// Define FETCH_PERF_EN to build the fetch/bubble performance counters.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h00000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        stall_PC,
    input  logic        stall_IFID,
    input  logic        flush_IFID,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jr_addr,
    input  logic [31:0] jump_addr,
    input  logic        halt,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr_IFID,
    output logic [31:0] npc_IFID,
    output logic        valid_IFID,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
);

    typedef enum logic [1:0] {StFetch, StRedir, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        load;
    logic        bubble_wr;

    assign redirect = (PCSrc != 2'd0);
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        target = branch_addr;
        case (PCSrc)
            2'd2:    target = jr_addr;
            2'd3:    target = jump_addr;
            default: target = branch_addr;
        endcase
        target[1:0] = 2'b00;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        load    = 1'b0;
        if (halt) begin
            state_d = StHalted;
            redir_d = '0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (redirect) begin
                        // A redirect overrides stall_PC; a word fetched alongside it is dropped.
                        if (ihit) begin
                            pc_d = target;
                        end else begin
                            redir_d = target;
                            state_d = StRedir;
                        end
                    end else if (ihit && !stall_PC) begin
                        pc_d = pc_plus4;
                        load = 1'b1;
                    end
                end
                StRedir: begin
                    if (ihit) begin
                        pc_d    = redirect ? target : redir_q;
                        redir_d = '0;
                        state_d = StFetch;
                    end else if (redirect) begin
                        redir_d = target;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        instr_d   = instr_q;
        npc_d     = npc_q;
        valid_d   = valid_q;
        bubble_wr = 1'b0;
        if (flush_IFID) begin
            instr_d   = '0;
            npc_d     = '0;
            valid_d   = 1'b0;
            bubble_wr = 1'b1;
        end else if (stall_IFID) begin
            bubble_wr = 1'b0;
        end else if (load) begin
            instr_d = imemload;
            npc_d   = pc_plus4;
            valid_d = 1'b1;
        end else begin
            instr_d   = '0;
            npc_d     = '0;
            valid_d   = 1'b0;
            bubble_wr = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StFetch;
            pc_q    <= PC_INIT;
            redir_q <= '0;
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign imemaddr   = pc_q;
    assign imemREN    = (state_q != StHalted);
    assign instr_IFID = instr_q;
    assign npc_IFID   = npc_q;
    assign valid_IFID = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Counters freeze once halted so the final values remain observable.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (state_q != StHalted) begin
            if (load) fetch_cnt_d = fetch_cnt_q + 32'd1;
            if (bubble_wr) bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`else
    logic unused_bubble_wr;
    assign unused_bubble_wr = bubble_wr;
    assign perf_fetch_cnt   = '0;
    assign perf_bubble_cnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table plus reset and wrap sequences.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        stall_PC, stall_IFID, flush_IFID, halt, ihit;
    logic [1:0]  PCSrc;
    logic [31:0] branch_addr, jr_addr, jump_addr, imemload;
    logic        imemREN, w_imemREN;
    logic [31:0] imemaddr, instr_IFID, npc_IFID, perf_fetch_cnt, perf_bubble_cnt;
    logic [31:0] w_imemaddr, w_instr_IFID, w_npc_IFID, w_perf_fetch_cnt, w_perf_bubble_cnt;
    logic        valid_IFID, w_valid_IFID;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    fetch_unit #(.PC_INIT(32'h00000000)) u_dut (
        .CLK(CLK), .nRST(nRST), .stall_PC(stall_PC), .stall_IFID(stall_IFID),
        .flush_IFID(flush_IFID), .PCSrc(PCSrc), .branch_addr(branch_addr),
        .jr_addr(jr_addr), .jump_addr(jump_addr), .halt(halt), .ihit(ihit),
        .imemload(imemload), .imemREN(imemREN), .imemaddr(imemaddr),
        .instr_IFID(instr_IFID), .npc_IFID(npc_IFID), .valid_IFID(valid_IFID),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
    );

    fetch_unit #(.PC_INIT(32'hFFFFFFFC)) u_wrap (
        .CLK(CLK), .nRST(nRST), .stall_PC(stall_PC), .stall_IFID(stall_IFID),
        .flush_IFID(flush_IFID), .PCSrc(PCSrc), .branch_addr(branch_addr),
        .jr_addr(jr_addr), .jump_addr(jump_addr), .halt(halt), .ihit(ihit),
        .imemload(imemload), .imemREN(w_imemREN), .imemaddr(w_imemaddr),
        .instr_IFID(w_instr_IFID), .npc_IFID(w_npc_IFID), .valid_IFID(w_valid_IFID),
        .perf_fetch_cnt(w_perf_fetch_cnt), .perf_bubble_cnt(w_perf_bubble_cnt)
    );

    typedef struct {
        logic        stall_pc;
        logic        stall_ifid;
        logic        flush;
        logic        hlt;
        logic        hit;
        logic [1:0]  src;
        logic [31:0] tgt;
        logic [31:0] load;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_npc;
        logic        e_valid;
        logic        e_ren;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic sp, input logic si, input logic fl, input logic hl,
                                input logic hit, input logic [1:0] src, input logic [31:0] tgt,
                                input logic [31:0] ld, input logic [31:0] ea,
                                input logic [31:0] ei, input logic [31:0] en,
                                input logic ev, input logic er);
        vec_t v;
        v.stall_pc = sp; v.stall_ifid = si; v.flush = fl; v.hlt = hl; v.hit = hit;
        v.src = src; v.tgt = tgt; v.load = ld;
        v.e_addr = ea; v.e_instr = ei; v.e_npc = en; v.e_valid = ev; v.e_ren = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall_PC    = v.stall_pc;
        stall_IFID  = v.stall_ifid;
        flush_IFID  = v.flush;
        halt        = v.hlt;
        ihit        = v.hit;
        PCSrc       = v.src;
        imemload    = v.load;
        // Unselected targets get a distinct value so a wrong mux select shows up.
        branch_addr = (v.src == 2'd1) ? v.tgt : ~v.tgt;
        jr_addr     = (v.src == 2'd2) ? v.tgt : ~v.tgt;
        jump_addr   = (v.src == 2'd3) ? v.tgt : ~v.tgt;
    endtask

    initial begin
        //          sp si fl hl hit src tgt           load          addr          instr         npc           v  ren
        vecs[0]  = mk(0, 0, 0, 0, 1, 0, 32'h0,        32'h20010005, 32'h4,        32'h20010005, 32'h4,        1, 1);
        vecs[1]  = mk(0, 0, 0, 0, 1, 0, 32'h0,        32'h11111111, 32'h8,        32'h11111111, 32'h8,        1, 1);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 32'h8,        32'h0,        32'h0,        0, 1);
        vecs[3]  = mk(0, 0, 0, 0, 1, 0, 32'h0,        32'h22222222, 32'hC,        32'h22222222, 32'hC,        1, 1);
        vecs[4]  = mk(1, 1, 0, 0, 1, 0, 32'h0,        32'h33333333, 32'hC,        32'h22222222, 32'hC,        1, 1);
        vecs[5]  = mk(1, 1, 0, 0, 1, 0, 32'h0,        32'h33333333, 32'hC,        32'h22222222, 32'hC,        1, 1);
        vecs[6]  = mk(1, 1, 0, 0, 1, 0, 32'h0,        32'h33333333, 32'hC,        32'h22222222, 32'hC,        1, 1);
        vecs[7]  = mk(0, 0, 0, 0, 1, 0, 32'h0,        32'h44444444, 32'h10,       32'h44444444, 32'h10,       1, 1);
        vecs[8]  = mk(0, 0, 0, 0, 0, 1, 32'h40,       32'h0,        32'h10,       32'h0,        32'h0,        0, 1);
        vecs[9]  = mk(0, 0, 0, 0, 1, 0, 32'h0,        32'h55555555, 32'h40,       32'h0,        32'h0,        0, 1);
        vecs[10] = mk(0, 0, 0, 0, 1, 0, 32'h0,        32'h66666666, 32'h44,       32'h66666666, 32'h44,       1, 1);
        vecs[11] = mk(0, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h44,       32'h0,        32'h0,        0, 1);
        vecs[12] = mk(0, 0, 0, 0, 1, 3, 32'h103,      32'h99999999, 32'h100,      32'h0,        32'h0,        0, 1);
        vecs[13] = mk(1, 0, 0, 0, 1, 2, 32'h81,       32'h99999999, 32'h80,       32'h0,        32'h0,        0, 1);
        vecs[14] = mk(0, 0, 0, 0, 0, 2, 32'h200,      32'h0,        32'h80,       32'h0,        32'h0,        0, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 1, 32'h302,      32'h0,        32'h80,       32'h0,        32'h0,        0, 1);
        vecs[16] = mk(0, 0, 0, 0, 1, 3, 32'h24,       32'h99999999, 32'h24,       32'h0,        32'h0,        0, 1);
        vecs[17] = mk(0, 0, 0, 1, 1, 0, 32'h0,        32'h77777777, 32'h24,       32'h0,        32'h0,        0, 0);
        vecs[18] = mk(0, 0, 0, 0, 1, 1, 32'h40,       32'h77777777, 32'h24,       32'h0,        32'h0,        0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h24,       32'h0,        32'h0,        0, 0);

        nRST = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        #12;
        chk("rst_addr", imemaddr, 32'h0);
        chk("rst_ren", {31'd0, imemREN}, 32'd1);
        chk("rst_instr", instr_IFID, 32'h0);
        chk("rst_npc", npc_IFID, 32'h0);
        chk("rst_valid", {31'd0, valid_IFID}, 32'd0);
        chk("rst_fcnt", perf_fetch_cnt, 32'h0);
        chk("rst_bcnt", perf_bubble_cnt, 32'h0);
        chk("rst_wrap_addr", w_imemaddr, 32'hFFFFFFFC);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            drive(vecs[i]);
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_addr", i), imemaddr, vecs[i].e_addr);
            chk($sformatf("v%0d_instr", i), instr_IFID, vecs[i].e_instr);
            chk($sformatf("v%0d_npc", i), npc_IFID, vecs[i].e_npc);
            chk($sformatf("v%0d_valid", i), {31'd0, valid_IFID}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_ren", i), {31'd0, imemREN}, {31'd0, vecs[i].e_ren});
            if (i == 0) begin
                chk("wrap_addr", w_imemaddr, 32'h0);
                chk("wrap_npc", w_npc_IFID, 32'h0);
                chk("wrap_instr", w_instr_IFID, 32'h20010005);
                chk("wrap_valid", {31'd0, w_valid_IFID}, 32'd1);
            end
        end

`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 32'd5);
        chk("perf_bubble", perf_bubble_cnt, 32'd10);
`else
        chk("perf_fetch_off", perf_fetch_cnt, 32'd0);
        chk("perf_bubble_off", perf_bubble_cnt, 32'd0);
`endif

        // Reset is the only way out of HALTED.
        @(negedge CLK);
        nRST = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        #1;
        chk("halt_rst_addr", imemaddr, 32'h0);
        chk("halt_rst_ren", {31'd0, imemREN}, 32'd1);

        // Reset while a redirect is pending must discard the latched target.
        @(negedge CLK);
        nRST = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 1, 32'h50, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        @(posedge CLK);
        #1;
        chk("redir_hold_addr", imemaddr, 32'h0);
        #2;
        nRST = 1'b0;
        #1;
        chk("redir_rst_addr", imemaddr, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        drive(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h88888888, 32'h0, 32'h0, 32'h0, 0, 0));
        @(posedge CLK);
        #1;
        chk("post_rst_addr", imemaddr, 32'h4);
        chk("post_rst_instr", instr_IFID, 32'h88888888);
        chk("post_rst_npc", npc_IFID, 32'h4);
        chk("post_rst_valid", {31'd0, valid_IFID}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h00000000, PC value loaded at reset.
REQ-002 SHALL have port CLK  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stall_PC  in  1  from hazard unit; hold PC.
REQ-005 SHALL have port stall_IFID  in  1  from hazard unit; hold IF/ID register.
REQ-006 SHALL have port flush_IFID  in  1  from hazard unit; clear IF/ID register.
REQ-007 SHALL have port PCSrc  in  2  next-PC select: 0 PC+4, 1 branch_addr, 2 jr_addr, 3 jump_addr.
REQ-008 SHALL have ports branch_addr, jr_addr, jump_addr  in  32 each  redirect targets.
REQ-009 SHALL have port halt  in  1  halt request from writeback.
REQ-010 SHALL have port ihit  in  1  instruction memory response valid.
REQ-011 SHALL have port imemload  in  32  fetched instruction.
REQ-012 SHALL have port imemREN  out  1  instruction read enable.
REQ-013 SHALL have port imemaddr  out  32  fetch address (current PC).
REQ-014 SHALL have ports instr_IFID  out  32, npc_IFID  out  32, valid_IFID  out  1  IF/ID register.
REQ-015 SHALL have ports perf_fetch_cnt, perf_bubble_cnt  out  32 each  performance counters.

Function
REQ-016 SHALL implement FSM states FETCH, REDIR, HALTED.
REQ-017 SHALL drive imemaddr = PC in all states; imemREN = 1 in FETCH/REDIR, 0 in HALTED.
REQ-018 Redirect = PCSrc != 0; target selected per REQ-007, bits [1:0] forced to 0.
REQ-019 FETCH, ihit=1, stall_PC=0, no redirect: PC <= PC+4 (modulo 2^32; 32'hFFFFFFFC wraps to 0).
REQ-020 FETCH, redirect, ihit=1: PC <= target next edge regardless of stall_PC; fetched word discarded; stay FETCH.
REQ-021 FETCH, redirect, ihit=0: latch target into redirect register; PC unchanged; go REDIR.
REQ-022 REDIR, ihit=1: discard fetched word, PC <= latched target, go FETCH.
REQ-023 REDIR, new redirect arrives: newest target overwrites latched one (same cycle as ihit: newest target used).
REQ-024 ihit=0, no redirect: PC holds.
REQ-025 IF/ID priority: flush_IFID (instr 0, npc 0, valid 0) > stall_IFID (hold) > load > bubble.
REQ-026 Load when FETCH, ihit=1, stall_PC=0, no redirect: instr_IFID <= imemload, npc_IFID <= PC+4, valid_IFID <= 1.
REQ-027 Otherwise (not flushed, not stalled, not loaded): bubble (instr 0, npc 0, valid 0).
REQ-028 halt=1 in any state: go HALTED next edge; PC frozen; pending redirect dropped; IF/ID rules of REQ-025 still apply with no loads.
REQ-029 HALTED SHALL be left only by reset.
REQ-030 1-cycle latency: imemload presented with ihit appears on instr_IFID after next rising edge.

Reset
REQ-031 nRST=0 SHALL asynchronously set PC=PC_INIT, state FETCH, redirect register 0, instr_IFID 0, npc_IFID 0, valid_IFID 0, counters 0.
REQ-032 Reset mid-REDIR SHALL discard latched target; first fetch after release at PC_INIT.

Configuration
REQ-033 Macro FETCH_PERF_EN defined: perf_fetch_cnt increments on each IF/ID load; perf_bubble_cnt increments on each cycle valid_IFID is written 0 (bubble or flush); both wrap at 2^32.
REQ-034 FETCH_PERF_EN undefined: counters not implemented; both outputs tied to 0.

Verification
REQ-035 Reset release, ihit=1 every cycle, imemload=32'h20010005 -> imemaddr 0,4,8; valid_IFID=1, npc_IFID=4 after first edge.
REQ-036 PC=32'h10, PCSrc=1, branch_addr=32'h40, ihit=0 one cycle then ihit=1 -> REDIR entered; fetched word dropped; next imemaddr=32'h40.
REQ-037 stall_IFID=1 and flush_IFID=1 same cycle with valid entry -> instr_IFID=0, valid_IFID=0.
REQ-038 stall_PC=1, stall_IFID=1, ihit=1 for 3 cycles -> imemaddr and IF/ID unchanged; release -> PC advances by 4.
REQ-039 PC_INIT=32'hFFFFFFFC, ihit=1 -> imemaddr wraps to 0, npc_IFID=0.
REQ-040 halt=1 at PC=32'h24 -> imemREN=0, imemaddr stays 32'h24 until nRST=0; with FETCH_PERF_EN, counters hold thereafter.
